// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared definitions for the barrel_shift_arbiter slice: shift-op encoding,
// width helpers and flat-vector slice helpers.
package barrel_shift_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_SHL = 2'd0,
        OP_SHR = 2'd1,
        OP_SRA = 2'd2
    } shift_op_e;

    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

    // Bit offset of element idx in a flat vector of w-bit fields.
    function automatic int unsigned lsb_of(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

    // The arith flag only matters for right shifts.
    function automatic shift_op_e decode_op(input logic dir, input logic arith);
        if (!dir)
            return OP_SHL;
        else if (arith)
            return OP_SRA;
        else
            return OP_SHR;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational N-bit barrel shifter: left, logical right or arithmetic right.
module barrel_shifter
    import barrel_shift_arbiter_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned M = $clog2(N)
) (
    input  logic [N-1:0] data,
    input  logic [M-1:0] shamt,
    input  shift_op_e    op,
    output logic [N-1:0] result
);

    always_comb begin
        result = data;
        unique case (op)
            OP_SHL:  result = data << shamt;
            OP_SHR:  result = data >> shamt;
            OP_SRA:  result = N'($signed(data) >>> shamt);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter between NREQ valid/ready
// requesters, with a single-entry registered result stage.
module barrel_shift_arbiter
    import barrel_shift_arbiter_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = $clog2(N),
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ*M-1:0] req_shamt,
    input  logic [NREQ-1:0]   req_dir,
    input  logic [NREQ-1:0]   req_arith,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [ID_W-1:0]   out_id
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            accept_en;
    logic            accept;
    logic [N-1:0]    sel_data;
    logic [M-1:0]    sel_shamt;
    shift_op_e       sel_op;
    logic [N-1:0]    shift_res;

    // Rotating-priority search starting at rr_ptr; first valid wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    assign accept_en = !out_valid || out_ready;
    assign accept    = gnt_any && accept_en && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_data  = req_data[lsb_of(int'(gnt_idx), N) +: N];
        sel_shamt = req_shamt[lsb_of(int'(gnt_idx), M) +: M];
        sel_op    = decode_op(req_dir[gnt_idx], req_arith[gnt_idx]);
    end

    barrel_shifter #(.N(N), .M(M)) u_shifter (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (shift_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= shift_res;
            out_id    <= gnt_idx;
            rr_ptr    <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
